// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot scan decoder slice.
package onehot_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Pure combinational N-to-2^N one-hot decode; zero forces an all-low output.
module onehot_dec #(
    parameter int N = 3,
    localparam int M = 2**N
) (
    input  logic [N-1:0] sel,
    input  logic         zero,
    output logic [M-1:0] onehot
);

    assign onehot = zero ? '0 : (M'(1) << sel);

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot select with direct/scan sequencing and break-before-make blanking.
module onehot_scan_decoder
    import onehot_pkg::*;
#(
    parameter int N         = 3,
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1,
    localparam int M        = 2**N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_n,
    input  logic               mode,
    input  logic [N-1:0]       enc,
    input  logic               enc_valid,
    output logic               enc_ready,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N-1:0]       scan_last,
    output logic [M-1:0]       dec,
    output logic [N-1:0]       idx,
    output logic               wrap
);

    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t             state, state_nx;
    logic               mode_q;
    logic [N-1:0]       enc_lat, enc_lat_nx;
    logic [N-1:0]       target, target_nx;
    logic [N-1:0]       idx_nx;
    logic               pend_wrap, pend_wrap_nx;
    logic               wrap_nx;
    logic [BW-1:0]      blank_cnt, blank_cnt_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;
    logic [DWELL_W-1:0] dwell_lat;
    logic [N-1:0]       last_lat;
    logic               restart;
    logic               accept;
    logic               sw;
    logic [N-1:0]       sw_tgt;
    logic               sw_wrap;
    logic [N-1:0]       nxt_scan;
    logic [M-1:0]       dec_nx;

    assign enc_ready = rst_n && !en_n && (mode == MODE_DIRECT) && (state != ST_BLANK);
    assign accept    = enc_valid && enc_ready;
    assign nxt_scan  = (idx >= last_lat) ? '0 : idx + 1'b1;

    // Any move to a different line funnels through sw so blanking is applied in one place.
    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        enc_lat_nx   = enc_lat;
        target_nx    = target;
        pend_wrap_nx = pend_wrap;
        blank_cnt_nx = blank_cnt;
        dwell_cnt_nx = dwell_cnt;
        wrap_nx      = 1'b0;
        restart      = 1'b0;
        sw           = 1'b0;
        sw_tgt       = target;
        sw_wrap      = 1'b0;

        if (accept) begin
            enc_lat_nx = enc;
        end

        if (en_n) begin
            state_nx     = ST_OFF;
            blank_cnt_nx = '0;
            dwell_cnt_nx = '0;
        end else if (state == ST_OFF || mode != mode_q) begin
            sw     = 1'b1;
            sw_tgt = (mode == MODE_SCAN) ? '0 : (accept ? enc : enc_lat);
        end else if (state == ST_BLANK) begin
            if (blank_cnt == BLANK_LAST) begin
                state_nx = ST_DRIVE;
                idx_nx   = target;
                wrap_nx  = pend_wrap;
                restart  = 1'b1;
            end else begin
                blank_cnt_nx = blank_cnt + 1'b1;
            end
        end else if (mode == MODE_DIRECT) begin
            if (accept && enc != idx) begin
                sw     = 1'b1;
                sw_tgt = enc;
            end
        end else if (dwell_cnt == dwell_lat) begin
            if (nxt_scan == idx) begin
                restart = 1'b1;
                wrap_nx = 1'b1;
            end else begin
                sw      = 1'b1;
                sw_tgt  = nxt_scan;
                sw_wrap = (nxt_scan == '0);
            end
        end else begin
            dwell_cnt_nx = dwell_cnt + 1'b1;
        end

        if (sw) begin
            if (BLANK_CYC == 0) begin
                state_nx = ST_DRIVE;
                idx_nx   = sw_tgt;
                wrap_nx  = sw_wrap;
                restart  = 1'b1;
            end else begin
                state_nx     = ST_BLANK;
                target_nx    = sw_tgt;
                pend_wrap_nx = sw_wrap;
                blank_cnt_nx = '0;
            end
        end

        if (restart) begin
            dwell_cnt_nx = '0;
        end
    end

    onehot_dec #(.N(N)) u_dec (
        .sel    (idx_nx),
        .zero   (state_nx != ST_DRIVE),
        .onehot (dec_nx)
    );

    // dwell and scan_last are only captured when the dwell counter restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            mode_q    <= MODE_DIRECT;
            enc_lat   <= '0;
            target    <= '0;
            idx       <= '0;
            pend_wrap <= 1'b0;
            wrap      <= 1'b0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            dwell_lat <= '0;
            last_lat  <= '0;
            dec       <= '0;
        end else begin
            state     <= state_nx;
            mode_q    <= mode;
            enc_lat   <= enc_lat_nx;
            target    <= target_nx;
            idx       <= idx_nx;
            pend_wrap <= pend_wrap_nx;
            wrap      <= wrap_nx;
            blank_cnt <= blank_cnt_nx;
            dwell_cnt <= dwell_cnt_nx;
            dec       <= dec_nx;
            if (restart) begin
                dwell_lat <= dwell;
                last_lat  <= scan_last;
            end
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench: one decoder with single-cycle blanking, one with blanking disabled.
module tb_onehot_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_n;
    logic       mode;
    logic [2:0] enc;
    logic       enc_valid;
    logic [7:0] dwell;
    logic [2:0] scan_last;

    logic       enc_ready, enc_ready0;
    logic [7:0] dec, dec0;
    logic [2:0] idx, idx0;
    logic       wrap, wrap0;

    int num_checks = 0;
    int num_fail   = 0;

    typedef struct {
        logic       en_n;
        logic       mode;
        logic [2:0] enc;
        logic       valid;
        logic [7:0] dwell;
        logic [2:0] last;
        logic [7:0] exp_dec;
        logic [2:0] exp_idx;
        logic       exp_wrap;
        logic       exp_ready;
        logic [7:0] exp_dec0;
    } vec_t;

    vec_t vecs [13];

    onehot_scan_decoder #(.N(3), .DWELL_W(8), .BLANK_CYC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_n      (en_n),
        .mode      (mode),
        .enc       (enc),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .dwell     (dwell),
        .scan_last (scan_last),
        .dec       (dec),
        .idx       (idx),
        .wrap      (wrap)
    );

    onehot_scan_decoder #(.N(3), .DWELL_W(8), .BLANK_CYC(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_n      (en_n),
        .mode      (mode),
        .enc       (enc),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready0),
        .dwell     (dwell),
        .scan_last (scan_last),
        .dec       (dec0),
        .idx       (idx0),
        .wrap      (wrap0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        en_n      = v.en_n;
        mode      = v.mode;
        enc       = v.enc;
        enc_valid = v.valid;
        dwell     = v.dwell;
        scan_last = v.last;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] scan_exp [17];
        logic [7:0] rot_exp;

        //          en_n  mode  enc   vld   dwell  last  dec    idx   wrap  rdy   dec0
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h01};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 8'h01, 3'd0, 1'b0, 1'b1, 8'h01};
        vecs[2]  = '{1'b0, 1'b0, 3'd5, 1'b1, 8'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h20};
        vecs[3]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'd0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1, 8'h20};
        vecs[4]  = '{1'b0, 1'b0, 3'd5, 1'b1, 8'd0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1, 8'h20};
        vecs[5]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'd0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1, 8'h20};
        vecs[6]  = '{1'b0, 1'b0, 3'd6, 1'b1, 8'd0, 3'd0, 8'h00, 3'd5, 1'b0, 1'b0, 8'h40};
        vecs[7]  = '{1'b0, 1'b0, 3'd6, 1'b0, 8'd0, 3'd0, 8'h40, 3'd6, 1'b0, 1'b1, 8'h40};
        vecs[8]  = '{1'b1, 1'b0, 3'd6, 1'b0, 8'd0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 3'd3, 1'b1, 8'd0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 3'd3, 1'b0, 8'd0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0, 8'h40};
        vecs[11] = '{1'b0, 1'b0, 3'd3, 1'b0, 8'd0, 3'd0, 8'h40, 3'd6, 1'b0, 1'b1, 8'h40};
        vecs[12] = '{1'b0, 1'b1, 3'd3, 1'b0, 8'd2, 3'd3, 8'h00, 3'd6, 1'b0, 1'b0, 8'h01};

        scan_exp = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00,
                     8'h04, 8'h04, 8'h04, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h01};

        rst_n = 1'b0;
        applyStimulus(vecs[0]);
        #1;
        checkOutput("reset dec", 32'(dec), 32'h0);
        tick();
        tick();
        checkOutput("reset dec held", 32'(dec), 32'h0);
        checkOutput("reset idx", 32'(idx), 32'h0);
        checkOutput("reset wrap", 32'(wrap), 32'h0);
        checkOutput("reset enc_ready", 32'(enc_ready), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("row%0d dec", i), 32'(dec), 32'(vecs[i].exp_dec));
            checkOutput($sformatf("row%0d idx", i), 32'(idx), 32'(vecs[i].exp_idx));
            checkOutput($sformatf("row%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
            checkOutput($sformatf("row%0d enc_ready", i), 32'(enc_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("row%0d dec noblank", i), 32'(dec0), 32'(vecs[i].exp_dec0));
        end

        // Scan rotation dwell=2, scan_last=3 continuing from the mode switch above.
        for (int k = 0; k < 17; k++) begin
            tick();
            checkOutput($sformatf("scan%0d dec", k), 32'(dec), 32'(scan_exp[k]));
            checkOutput($sformatf("scan%0d wrap", k), 32'(wrap), (k == 16) ? 32'h1 : 32'h0);
        end

        en_n = 1'b1;
        tick();
        checkOutput("scan disable dec", 32'(dec), 32'h0);
        checkOutput("scan disable wrap", 32'(wrap), 32'h0);
        en_n = 1'b0;
        tick();
        checkOutput("scan reenable blank", 32'(dec), 32'h0);
        tick();
        checkOutput("scan reenable dec", 32'(dec), 32'h01);
        checkOutput("scan reenable wrap", 32'(wrap), 32'h0);

        mode = 1'b0;
        tick();
        checkOutput("to direct blank", 32'(dec), 32'h0);
        checkOutput("to direct ready", 32'(enc_ready), 32'h0);
        tick();
        checkOutput("to direct dec", 32'(dec), 32'h40);
        checkOutput("to direct idx", 32'(idx), 32'h6);

        enc       = 3'd3;
        enc_valid = 1'b1;
        tick();
        checkOutput("pre-reset blank", 32'(dec), 32'h0);
        enc_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset dec", 32'(dec), 32'h0);
        checkOutput("async reset idx", 32'(idx), 32'h0);
        checkOutput("async reset ready", 32'(enc_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("post-reset blank", 32'(dec), 32'h0);
        tick();
        checkOutput("post-reset dec", 32'(dec), 32'h01);

        enc       = 3'd2;
        enc_valid = 1'b1;
        tick();
        checkOutput("enc2 blank", 32'(dec), 32'h0);
        enc_valid = 1'b0;
        tick();
        checkOutput("enc2 dec", 32'(dec), 32'h04);
        mode = 1'b1;
        tick();
        checkOutput("to scan blank", 32'(dec), 32'h0);
        tick();
        checkOutput("to scan dec", 32'(dec), 32'h01);
        mode = 1'b0;
        tick();
        checkOutput("back to direct blank", 32'(dec), 32'h0);
        tick();
        checkOutput("back to direct dec", 32'(dec), 32'h04);
        checkOutput("back to direct idx", 32'(idx), 32'h2);

        // No-blanking instance: full-speed rotation over all eight lines.
        rst_n     = 1'b0;
        mode      = 1'b1;
        dwell     = 8'd0;
        scan_last = 3'd7;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            rot_exp = 8'h01 << (k % 8);
            checkOutput($sformatf("rot%0d dec", k), 32'(dec0), 32'(rot_exp));
            checkOutput($sformatf("rot%0d wrap", k), 32'(wrap0), (k > 0 && k % 8 == 0) ? 32'h1 : 32'h0);
        end

        scan_last = 3'd0;
        tick();
        checkOutput("last0 step dec", 32'(dec0), 32'h02);
        checkOutput("last0 step wrap", 32'(wrap0), 32'h0);
        tick();
        checkOutput("last0 wrap dec", 32'(dec0), 32'h01);
        checkOutput("last0 wrap", 32'(wrap0), 32'h1);
        tick();
        checkOutput("last0 redrive dec", 32'(dec0), 32'h01);
        checkOutput("last0 redrive wrap", 32'(wrap0), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with an active-low enable.
- Two modes:
  - Direct: the driven index is loaded through a valid/ready handshake.
  - Scan: an internal sequencer rotates the active line with a programmable dwell time.
- Break-before-make blanking: all outputs are held low for a programmable number of cycles between any two different active lines.
- Drives row/digit selects and chip-select fans in the datapath, wherever a glitch-free, multi-cycle one-hot select is required.

Parameters:
N, 3, index width
M, 2**N, output width (derived, not overridden)
DWELL_W, 8, width of dwell count input
BLANK_CYC, 1, blanking cycles between different active lines (0 = no blanking)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en_n  input  1  active-low enable; 1 forces dec to all-zero
mode  input  1  0 = direct, 1 = scan
enc  input  N  index to drive (direct mode)
enc_valid  input  1  enc is valid
enc_ready  output  1  block accepts enc this cycle
dwell  input  DWELL_W  scan: each line active for dwell+1 cycles
scan_last  input  N  scan: highest index visited before wrap to 0
dec  output  M  registered one-hot (or all-zero) select
idx  output  N  index currently driven (or last driven while blanking/off)
wrap  output  1  one-cycle pulse when scan re-drives index 0 after scan_last

Behaviour:
- Reset (rst_n low, async):
  - dec=0, idx=0, wrap=0, latched enc=0, dwell counter=0, state OFF.
  - enc_ready=0 while rst_n is low.
- States:
  - OFF: dec=0.
  - BLANK: dec=0, counts BLANK_CYC cycles.
  - DRIVE: dec = one-hot of idx.
- en_n=1 in any state: next edge goes to OFF, dec=0, counters cleared, latched enc and idx kept.
- OFF and en_n=0:
  - BLANK_CYC>0 → BLANK.
  - BLANK_CYC=0 → DRIVE directly.
  - Target is the latched enc in direct mode, index 0 in scan mode.
- BLANK: after BLANK_CYC cycles → DRIVE with the pending target; idx updates on entry to DRIVE.
- Direct mode:
  - enc_ready = (en_n==0) && (mode==0) && (state != BLANK) && rst_n.
  - Transfer occurs on an edge where enc_valid && enc_ready; enc is latched.
  - If enc == idx and state is DRIVE: no change, no blanking.
  - Otherwise with BLANK_CYC=0: dec shows the new one-hot after the accepting edge (1-cycle latency).
  - Otherwise with BLANK_CYC=B>0: dec=0 for B cycles after the accepting edge, then the new one-hot.
  - In DRIVE, dec is held indefinitely until a new transfer arrives.
- Scan mode:
  - In DRIVE, the dwell counter counts 0..dwell; idx is held for dwell+1 cycles (dwell=0 → 1 cycle).
  - At dwell end, the next index is idx+1, or 0 if idx >= scan_last (covers scan_last lowered mid-scan).
  - Next index ≠ idx: BLANK then DRIVE.
  - Next index = idx (scan_last=0): stay in DRIVE, no blanking, counter restarts.
  - dwell and scan_last are sampled when the counter restarts.
  - wrap=1 for exactly the first DRIVE cycle of index 0 reached by wrap-around, including scan_last=0 re-drive; not asserted on the initial entry from OFF or a mode change.
- Mode change while enabled: next edge → BLANK (or DRIVE if BLANK_CYC=0).
  - Target: latched enc when entering direct, 0 when entering scan.
  - A pending handshake on the same edge as a direct→scan switch is not accepted (enc_ready already 0 under mode=1).
- Invariant: dec is never multi-hot; dec != 0 only in DRIVE, and then dec == 1<<idx.
- wrap is 0 outside scan-mode DRIVE.

Decomposition:
- Shared package onehot_pkg:
  - state encoding typedef (OFF, BLANK, DRIVE).
  - MODE_DIRECT=0, MODE_SCAN=1 constants.
- One sub-module: onehot_dec (pure combinational N→M decode with zero-force input), instantiated for the dec register input.
- Sequencer, dwell counter and blanking counter stay in the top.

Test Plan:
- Reset with en_n=0, mode=0 → dec=0, idx=0, enc_ready=0 while rst_n low; 1+BLANK_CYC cycles after release dec=8'h01.
- N=3, BLANK_CYC=1, direct: send enc=5 → dec=0 for 1 cycle, then 8'h20, idx=5; resend enc=5 → no blank cycle, dec stays 8'h20.
- Scan with dwell=2, scan_last=3, BLANK_CYC=1 → dec sequence 01×3, 00, 02×3, 00, 04×3, 00, 08×3, 00, 01 with wrap=1 only on that last 01 cycle.
- Scan with BLANK_CYC=0, dwell=0, scan_last=7 → dec rotates 01,02,…,80,01 every cycle; wrap once per 8 cycles.
- en_n raised mid-DRIVE at idx=6 → dec=0 on the next edge; en_n lowered in scan mode → BLANK then restart at 01.
- Async rst_n pulse mid-BLANK between clock edges → dec=0 immediately, state OFF; mode switch 1→0 with latched enc=2 → blank then 8'h04.
